// File: rtl/serial_pkg.sv
// Shared definitions for the serial byte transmitter.
// Contents: FSM state encoding, default frame geometry, bit-order codes and
// a counter-width helper that never returns zero.
package serial_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] PAR  = 2'd2;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DIV   = 4;

    localparam logic ORDER_MSB_FIRST = 1'b0;
    localparam logic ORDER_LSB_FIRST = 1'b1;

    // clog2 with a floor of one bit so DIV=1 still yields a legal vector
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_byte_tx_bit_timer.sv
// bit_timer: DIV-cycle bit-period divider.
// Ports:
//   clk        in  clock
//   rst        in  synchronous active-high reset
//   clear      in  restart the period at count 0 on the next cycle
//   en         in  advance the count (frame in progress)
//   last_c     out current cycle is the last of the bit period
//   last_nxt_c out next cycle will be the last of the bit period
module bit_timer
    import serial_pkg::*;
#(
    parameter int unsigned DIV = DEFAULT_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic last_c,
    output logic last_nxt_c
);

    localparam int unsigned DW = cnt_width(DIV);

    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_nxt;

    assign last_c = (cnt == DW'(DIV - 1));

    // Count parks at 0 outside a frame, so every frame starts clean
    always_comb begin
        cnt_nxt = '0;
        if (clear) begin
            cnt_nxt = '0;
        end else if (en && !last_c) begin
            cnt_nxt = cnt + DW'(1);
        end
    end

    assign last_nxt_c = (cnt_nxt == DW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/serial_byte_tx.sv
// serial_byte_tx: parallel-to-serial transmitter for a downstream shift register.
// Optional even-parity bit period enabled by macro SERIAL_BYTE_TX_PARITY_EN.
// Ports:
//   C          in  clock
//   R          in  synchronous active-high reset
//   DIN        in  byte to send
//   DIN_VALID  in  DIN is valid
//   DIN_READY  out idle, can accept
//   LEFT_RIGHT in  0: MSB first, 1: LSB first (captured at accept)
//   SO         out serial data
//   SHIFT_EN   out one-cycle strobe in the last cycle of each data bit
//   PAR_SLOT   out parity bit on SO (0 without the macro)
//   BUSY       out frame in progress
//   DONE       out one-cycle pulse in the first idle cycle after a frame
module serial_byte_tx
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DIV   = DEFAULT_DIV
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    input  logic             LEFT_RIGHT,
    output logic             SO,
    output logic             SHIFT_EN,
    output logic             PAR_SLOT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned BCW = $clog2(WIDTH + 1);

    logic [1:0]       state,   state_nxt;
    logic [WIDTH-1:0] shreg,   shreg_nxt;
    logic             lr,      lr_nxt;
    logic [BCW-1:0]   bit_cnt, bit_cnt_nxt;
    logic             so_nxt;
    logic             shift_en_nxt;
    logic             accept_c;
    logic             last_c;
    logic             last_nxt_c;

    assign accept_c = (state == IDLE) && DIN_VALID;

    bit_timer #(.DIV(DIV)) u_bit_timer (
        .clk        (C),
        .rst        (R),
        .clear      (accept_c),
        .en         (state != IDLE),
        .last_c     (last_c),
        .last_nxt_c (last_nxt_c)
    );

`ifdef SERIAL_BYTE_TX_PARITY_EN
    logic par, par_nxt;
`endif

    // Next-state, shift register and bit counter
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        lr_nxt      = lr;
        bit_cnt_nxt = bit_cnt;
`ifdef SERIAL_BYTE_TX_PARITY_EN
        par_nxt     = par;
`endif
        case (state)
            IDLE: begin
                if (DIN_VALID) begin
                    state_nxt   = DATA;
                    shreg_nxt   = DIN;
                    lr_nxt      = LEFT_RIGHT;
                    bit_cnt_nxt = '0;
`ifdef SERIAL_BYTE_TX_PARITY_EN
                    par_nxt     = ^DIN;
`endif
                end
            end
            DATA: begin
                if (last_c) begin
                    bit_cnt_nxt = bit_cnt + BCW'(1);
                    // Current bit always sits at the end selected by lr
                    shreg_nxt   = lr ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};
                    if (bit_cnt == BCW'(WIDTH - 1)) begin
`ifdef SERIAL_BYTE_TX_PARITY_EN
                        state_nxt = PAR;
`else
                        state_nxt = IDLE;
`endif
                    end
                end
            end
            PAR: begin
                if (last_c) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output lookahead so every output is a flop
    always_comb begin
        so_nxt = 1'b0;
        if (state_nxt == DATA) begin
            so_nxt = lr_nxt ? shreg_nxt[0] : shreg_nxt[WIDTH-1];
        end
`ifdef SERIAL_BYTE_TX_PARITY_EN
        else if (state_nxt == PAR) begin
            so_nxt = par_nxt;
        end
`endif
        shift_en_nxt = (state_nxt == DATA) && last_nxt_c;
    end

    always_ff @(posedge C) begin
        if (R) begin
            state     <= IDLE;
            shreg     <= '0;
            lr        <= 1'b0;
            bit_cnt   <= '0;
            SO        <= 1'b0;
            SHIFT_EN  <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            DIN_READY <= 1'b1;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            lr        <= lr_nxt;
            bit_cnt   <= bit_cnt_nxt;
            SO        <= so_nxt;
            SHIFT_EN  <= shift_en_nxt;
            BUSY      <= (state_nxt != IDLE);
            DONE      <= (state != IDLE) && (state_nxt == IDLE);
            DIN_READY <= (state_nxt == IDLE);
        end
    end

`ifdef SERIAL_BYTE_TX_PARITY_EN
    always_ff @(posedge C) begin
        if (R) begin
            par      <= 1'b0;
            PAR_SLOT <= 1'b0;
        end else begin
            par      <= par_nxt;
            PAR_SLOT <= (state_nxt == PAR);
        end
    end
`else
    assign PAR_SLOT = 1'b0;
`endif

endmodule
